// File: rtl/i2c_reg_ctrl_pkg.sv
// Shared definitions for the I2C register-access sequencer.
//   state_e   : 4-bit FSM state encoding (14 used codes, 14/15 unused)
//   RW_WRITE  : address-byte direction bit for a write (0)
//   RW_READ   : address-byte direction bit for a read (1)
//   addr_byte : builds the on-wire address byte {addr7, rw}
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle        = 4'd0,
        StIssueStart  = 4'd1,
        StWaitStart   = 4'd2,
        StIssueReg    = 4'd3,
        StWaitReg     = 4'd4,
        StIssueWdata  = 4'd5,
        StWaitWdata   = 4'd6,
        StIssueRstart = 4'd7,
        StWaitRstart  = 4'd8,
        StIssueRead   = 4'd9,
        StWaitRead    = 4'd10,
        StIssueStop   = 4'd11,
        StWaitStop    = 4'd12,
        StResp        = 4'd13
    } state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr7, input logic rw);
        return {addr7, rw};
    endfunction

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Byte-level I2C engine command/status bus.
//   master modport : sequencer side, drives command pulses, ack_in and data_in
//   slave modport  : engine side, returns done, ack_err and received data
interface i2c_reg_ctrl_if;
    logic       m_start;
    logic       m_stop;
    logic       m_write;
    logic       m_read;
    logic       m_ack_in;
    logic [7:0] m_data_in;
    logic       m_done;
    logic       m_ack_err;
    logic [7:0] m_data_out;

    modport master (
        output m_start, m_stop, m_write, m_read, m_ack_in, m_data_in,
        input  m_done, m_ack_err, m_data_out
    );

    modport slave (
        input  m_start, m_stop, m_write, m_read, m_ack_in, m_data_in,
        output m_done, m_ack_err, m_data_out
    );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// Single-register I2C read/write sequencer in front of a byte-level I2C engine.
// Splits each accepted command into START/WRITE/READ/STOP engine operations
// and reports completion with read data and an error flag.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only in idle)
//   cmd_rw, dev_addr,
//   reg_addr, wr_data   : command fields, latched on accept
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata, rsp_err  : read byte (held until next read) and NACK/timeout flag
//   busy                : high from accept until rsp_valid
//   eng                 : engine bus (master side)
// Build option: define I2C_REG_TIMEOUT_EN to abort a WAIT state after TIMEOUT_CYC
// cycles without m_done (no STOP is issued in that case).
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned CNT_W       = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_rw,
    input  logic [6:0]     dev_addr,
    input  logic [7:0]     reg_addr,
    input  logic [7:0]     wr_data,
    output logic           rsp_valid,
    output logic [7:0]     rsp_rdata,
    output logic           rsp_err,
    output logic           busy,
    i2c_reg_ctrl_if.master eng
);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYC");
    end

    state_e     state_q;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdat_q;
    logic       err_q;
    logic       cmd_ready_q;
    logic       busy_q;
    logic       rsp_valid_q;
    logic       rsp_err_q;
    logic [7:0] rsp_rdata_q;
    logic       start_q;
    logic       stop_q;
    logic       write_q;
    logic       read_q;
    logic [7:0] data_in_q;
    logic       timeout;

`ifdef I2C_REG_TIMEOUT_EN
    logic             in_wait;
    logic [CNT_W-1:0] cnt_q;

    assign in_wait = state_q inside {StWaitStart, StWaitReg, StWaitWdata, StWaitRstart,
                                     StWaitRead, StWaitStop};

    // Cleared in every non-WAIT state, so it starts at 0 on each WAIT entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (in_wait) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = in_wait && !eng.m_done && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // Pulses are loaded on the transition into an ISSUE state, so each pulse
    // is high exactly while the FSM sits in that ISSUE state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rw_q        <= RW_WRITE;
            dev_q       <= '0;
            reg_q       <= '0;
            wdat_q      <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            data_in_q   <= '0;
        end else begin
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            if (timeout) begin
                // Engine presumed hung: report straight away without a STOP.
                err_q       <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                state_q     <= StResp;
            end else begin
                case (state_q)
                    StIdle: begin
                        cmd_ready_q <= 1'b1;
                        if (cmd_valid && cmd_ready_q) begin
                            rw_q        <= cmd_rw;
                            dev_q       <= dev_addr;
                            reg_q       <= reg_addr;
                            wdat_q      <= wr_data;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            start_q     <= 1'b1;
                            data_in_q   <= addr_byte(dev_addr, RW_WRITE);
                            state_q     <= StIssueStart;
                        end
                    end
                    StIssueStart:  state_q <= StWaitStart;
                    StIssueReg:    state_q <= StWaitReg;
                    StIssueWdata:  state_q <= StWaitWdata;
                    StIssueRstart: state_q <= StWaitRstart;
                    StIssueRead:   state_q <= StWaitRead;
                    StIssueStop:   state_q <= StWaitStop;
                    StWaitStart: begin
                        if (eng.m_done) begin
                            if (eng.m_ack_err) begin
                                err_q   <= 1'b1;
                                stop_q  <= 1'b1;
                                state_q <= StIssueStop;
                            end else begin
                                write_q   <= 1'b1;
                                data_in_q <= reg_q;
                                state_q   <= StIssueReg;
                            end
                        end
                    end
                    StWaitReg: begin
                        if (eng.m_done) begin
                            if (eng.m_ack_err) begin
                                err_q   <= 1'b1;
                                stop_q  <= 1'b1;
                                state_q <= StIssueStop;
                            end else if (rw_q == RW_READ) begin
                                start_q   <= 1'b1;
                                data_in_q <= addr_byte(dev_q, RW_READ);
                                state_q   <= StIssueRstart;
                            end else begin
                                write_q   <= 1'b1;
                                data_in_q <= wdat_q;
                                state_q   <= StIssueWdata;
                            end
                        end
                    end
                    StWaitWdata: begin
                        if (eng.m_done) begin
                            err_q   <= eng.m_ack_err;
                            stop_q  <= 1'b1;
                            state_q <= StIssueStop;
                        end
                    end
                    StWaitRstart: begin
                        if (eng.m_done) begin
                            if (eng.m_ack_err) begin
                                err_q   <= 1'b1;
                                stop_q  <= 1'b1;
                                state_q <= StIssueStop;
                            end else begin
                                read_q  <= 1'b1;
                                state_q <= StIssueRead;
                            end
                        end
                    end
                    StWaitRead: begin
                        if (eng.m_done) begin
                            rsp_rdata_q <= eng.m_data_out;
                            stop_q      <= 1'b1;
                            state_q     <= StIssueStop;
                        end
                    end
                    StWaitStop: begin
                        if (eng.m_done) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= err_q;
                            state_q     <= StResp;
                        end
                    end
                    StResp: begin
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        err_q       <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= StIdle;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign eng.m_start   = start_q;
    assign eng.m_stop    = stop_q;
    assign eng.m_write   = write_q;
    assign eng.m_read    = read_q;
    assign eng.m_data_in = data_in_q;
    // Only single-byte reads, so the one byte read is always the last: NACK it.
    assign eng.m_ack_in  = 1'b1;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: behavioural engine + slave register
// model on the engine bus, table-driven directed commands, hand-written corner
// sequences and randomized commands against a reference model.
module tb_i2c_reg_ctrl;

    localparam int K_S = 0;
    localparam int K_W = 1;
    localparam int K_R = 2;
    localparam int K_P = 3;
    localparam int NONE = 99;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr, wr_data, rsp_rdata;
    logic       rsp_valid, rsp_err, busy;

    always #5 clk = ~clk;

    i2c_reg_ctrl_if bus();

    i2c_reg_ctrl #(.TIMEOUT_CYC(50), .CNT_W(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng       (bus)
    );

    int         total = 0;
    int         bad = 0;
    int         eng_nack = NONE;
    int         eng_fix = 0;
    int         eng_idx = 0;
    int         stop_cnt = 0;
    bit         eng_hang = 1'b0;
    logic [9:0] ops[$];
    logic [7:0] smem[256];
    logic [7:0] ref_mem[256];
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor: records every command pulse as {kind, byte}.
    always @(negedge clk) begin
        int n;
        if (reset) begin
            n = int'(bus.m_start) + int'(bus.m_stop) + int'(bus.m_write) + int'(bus.m_read);
            if (n != 0) begin
                chk("pulse_onehot", n, 1);
                if (bus.m_start)      ops.push_back({2'(K_S), bus.m_data_in});
                else if (bus.m_write) ops.push_back({2'(K_W), bus.m_data_in});
                else if (bus.m_read)  ops.push_back({2'(K_R), 7'b0, bus.m_ack_in});
                else                  ops.push_back({2'(K_P), 8'h00});
                if (bus.m_stop) stop_cnt++;
            end
        end
    end

    // Engine + slave model: answers each pulse after 1..4 cycles.
    int         e_kind, e_delay;
    logic [7:0] e_byte, s_ptr;
    bit         e_abort, e_nk, s_need_ptr;
    initial begin
        bus.m_done = 1'b0;
        bus.m_ack_err = 1'b0;
        bus.m_data_out = 8'h00;
        s_ptr = 8'h00;
        s_need_ptr = 1'b1;
        @(negedge clk);
        forever begin
            if (reset && !eng_hang &&
                (bus.m_start || bus.m_stop || bus.m_write || bus.m_read)) begin
                e_kind = bus.m_start ? K_S : bus.m_write ? K_W : bus.m_read ? K_R : K_P;
                e_byte = bus.m_data_in;
                e_delay = (eng_fix > 0) ? eng_fix : int'($urandom_range(0, 3));
                e_abort = 1'b0;
                for (int i = 0; i <= e_delay; i++) begin
                    @(negedge clk);
                    if (!reset) e_abort = 1'b1;
                end
                if (!e_abort) begin
                    if (e_kind == K_S || e_kind == K_W) chk("data_in_stable", bus.m_data_in, e_byte);
                    e_nk = (eng_idx == eng_nack);
                    bus.m_data_out = 8'($urandom);
                    case (e_kind)
                        K_S: s_need_ptr = !e_byte[0];
                        K_W: begin
                            if (s_need_ptr) begin
                                s_ptr = e_byte;
                                s_need_ptr = 1'b0;
                            end else if (!e_nk) begin
                                smem[s_ptr] = e_byte;
                                s_ptr++;
                            end
                        end
                        K_R: begin
                            bus.m_data_out = smem[s_ptr];
                            s_ptr++;
                        end
                        default: ;
                    endcase
                    bus.m_done = 1'b1;
                    bus.m_ack_err = e_nk;
                    @(negedge clk);
                    bus.m_done = 1'b0;
                    bus.m_ack_err = 1'b0;
                    if (e_kind == K_P) chk("stop_to_rsp_latency", rsp_valid, 1);
                end
                eng_idx++;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic wait_ready();
        int wt = 0;
        while (!cmd_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    // Reference model: expected ops/err/rdata from the command rules, then run it.
    task automatic do_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input int nack, output logic got_err,
                          output logic [7:0] got_rd, output int got_nops);
        logic [9:0] full[$];
        logic [9:0] exp_q[$];
        logic       exp_err;
        logic [7:0] exp_rd;
        int         wt;
        if (rw) full = '{{2'(K_S), dev, 1'b0}, {2'(K_W), rg}, {2'(K_S), dev, 1'b1},
                         {2'(K_R), 8'h01}, {2'(K_P), 8'h00}};
        else    full = '{{2'(K_S), dev, 1'b0}, {2'(K_W), rg}, {2'(K_W), wd},
                         {2'(K_P), 8'h00}};
        exp_err = (nack < 3);
        if (exp_err) begin
            for (int i = 0; i <= nack; i++) exp_q.push_back(full[i]);
            exp_q.push_back({2'(K_P), 8'h00});
        end else begin
            exp_q = full;
        end
        exp_rd = last_rd;
        if (rw && !exp_err) exp_rd = ref_mem[rg];
        if (!rw && !exp_err) ref_mem[rg] = wd;

        wait_ready();
        ops.delete();
        eng_idx = 0;
        eng_nack = nack;
        cmd_valid = 1'b1;
        cmd_rw = rw;
        dev_addr = dev;
        reg_addr = rg;
        wr_data = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_rw = 1'($urandom);
        dev_addr = 7'($urandom);
        reg_addr = 8'($urandom);
        wr_data = 8'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("ready_low_after_accept", cmd_ready, 0);
        chk("accept_to_start", bus.m_start, 1);
        wt = 0;
        while (!rsp_valid && wt < 300) begin
            @(negedge clk);
            wt++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
        got_err = rsp_err;
        got_rd = rsp_rdata;
        got_nops = ops.size();
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("op_count", ops.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ops.size(); i++) chk("op_seq", ops[i], exp_q[i]);
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
        last_rd = exp_rd;
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        int         nack;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_nops;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic       g_err;
        logic [7:0] g_rd;
        int         g_n, wt, cyc, first_rsp, second_acc, busy_low, stops0;

        cmd_valid = 1'b0;
        cmd_rw = 1'b0;
        dev_addr = '0;
        reg_addr = '0;
        wr_data = '0;
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        smem[8'h32] = 8'hA5;
        ref_mem[8'h32] = 8'hA5;

        vt[0] = '{1'b0, 7'h1D, 8'h2D, 8'h08, NONE, 1'b0, 8'h00, 4};
        vt[1] = '{1'b1, 7'h1D, 8'h32, 8'h00, NONE, 1'b0, 8'hA5, 5};
        vt[2] = '{1'b0, 7'h1D, 8'h10, 8'h55, 0,    1'b1, 8'hA5, 2};
        vt[3] = '{1'b1, 7'h1D, 8'h2D, 8'h00, NONE, 1'b0, 8'h08, 5};
        vt[4] = '{1'b0, 7'h1D, 8'h11, 8'h66, 1,    1'b1, 8'h08, 3};
        vt[5] = '{1'b0, 7'h1D, 8'h12, 8'h77, 2,    1'b1, 8'h08, 4};
        vt[6] = '{1'b1, 7'h1D, 8'h32, 8'h00, 2,    1'b1, 8'h08, 4};
        vt[7] = '{1'b1, 7'h1D, 8'h12, 8'h00, NONE, 1'b0, 8'h48, 5};
        vt[8] = '{1'b1, 7'h1D, 8'h2D, 8'h00, 3,    1'b0, 8'h08, 5};
        vt[9] = '{1'b0, 7'h1D, 8'h20, 8'h99, 3,    1'b0, 8'h08, 4};

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_pulses", {bus.m_start, bus.m_stop, bus.m_write, bus.m_read}, 0);
        chk("rst_ack_in", bus.m_ack_in, 1);
        chk("rst_data_in", bus.m_data_in, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", cmd_ready, 1);

        for (int i = 0; i < 10; i++) begin
            do_cmd(vt[i].rw, vt[i].dev, vt[i].rg, vt[i].wd, vt[i].nack, g_err, g_rd, g_n);
            chk($sformatf("vec%0d_err", i), g_err, vt[i].exp_err);
            chk($sformatf("vec%0d_rdata", i), g_rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_nops", i), g_n, vt[i].exp_nops);
        end

        // Reset asserted while waiting for the register-address write.
        eng_fix = 10;
        wait_ready();
        ops.delete();
        eng_idx = 0;
        eng_nack = NONE;
        cmd_valid = 1'b1;
        cmd_rw = 1'b0;
        dev_addr = 7'h1D;
        reg_addr = 8'h40;
        wr_data = 8'h3C;
        @(negedge clk);
        cmd_valid = 1'b0;
        wt = 0;
        while (!bus.m_write && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        chk("saw_reg_write", bus.m_write, 1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_pulses", {bus.m_start, bus.m_stop, bus.m_write, bus.m_read}, 0);
        chk("midrst_data_in", bus.m_data_in, 0);
        chk("midrst_ack_in", bus.m_ack_in, 1);
        chk("midrst_rdata", rsp_rdata, 0);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        eng_fix = 0;
        last_rd = 8'h00;
        @(negedge clk);
        chk("midrst_ready_after", cmd_ready, 1);
        do_cmd(1'b0, 7'h1D, 8'h41, 8'h5A, NONE, g_err, g_rd, g_n);
        chk("midrst_next_err", g_err, 0);

        // cmd_valid held high across two commands.
        wait_ready();
        eng_nack = NONE;
        cmd_valid = 1'b1;
        cmd_rw = 1'b0;
        dev_addr = 7'h1D;
        reg_addr = 8'h05;
        wr_data = 8'h11;
        cyc = 0;
        first_rsp = -1;
        second_acc = -1;
        busy_low = 0;
        while (second_acc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_low++;
            if (rsp_valid && first_rsp < 0) first_rsp = cyc;
            if (first_rsp >= 0 && cmd_ready) second_acc = cyc;
        end
        chk("b2b_second_accept", second_acc, first_rsp + 1);
        chk("b2b_busy_gap", busy_low, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_busy_second", busy, 1);
        wt = 0;
        while (!rsp_valid && wt < 300) begin
            @(negedge clk);
            wt++;
        end
        chk("b2b_second_rsp", rsp_valid, 1);
        chk("b2b_second_err", rsp_err, 0);
        @(negedge clk);

        // Randomized commands.
        for (int i = 0; i < 40; i++) begin
            int nk;
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : NONE;
            do_cmd(1'($urandom), 7'($urandom), 8'h10 + 8'($urandom_range(0, 7)),
                   8'($urandom), nk, g_err, g_rd, g_n);
        end

`ifdef I2C_REG_TIMEOUT_EN
        // Hung engine: no m_done ever.
        eng_hang = 1'b1;
        wait_ready();
        stops0 = stop_cnt;
        cmd_valid = 1'b1;
        cmd_rw = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("tmo_start", bus.m_start, 1);
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_latency", cyc, 51);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_no_stop", stop_cnt, stops0);
        @(negedge clk);
        eng_hang = 1'b0;
`else
        stops0 = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
